// File: rtl/cpu_data_mem_responder_pkg.sv
// Shared types and helpers for the CPU data-memory responder.
// State encoding, default widths and the word-index range check.
package mem_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } mem_state_t;

    function automatic logic in_range(input logic [31:0] index, input logic [31:0] depth);
        return (index < depth);
    endfunction

endpackage

// File: rtl/cpu_data_mem_responder_sp_word_ram.sv
// Single-port word RAM: one write port, write-first registered read.
// The read register can be forced to zero so out-of-range loads never return stale words.
module sp_word_ram #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32,
    parameter int AW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_zero,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage array write; left unreset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: write-first, held whenever reads are disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            if (rd_zero) begin
                rdata_r <= {DATA_W{1'b0}};
            end else if (we) begin
                rdata_r <= wdata;
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cpu_data_mem_responder.sv
// Data-memory responder for the CPU scalar port: clears the RAM after reset,
// takes a host preload stream, then serves CPU loads/stores with sticky error flags.
module cpu_data_mem_responder #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataWrite,
    input  logic              memWrite,
    output logic [DATA_W-1:0] dataRead,
    output logic              ready,
    input  logic              load_en,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              err_range,
    output logic              err_align,
    input  logic              err_clr
);
    import mem_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int IW = ADDR_W - 2;

    mem_state_t        state_r, next_state_s;
    logic [AW-1:0]     clr_cnt_r;
    logic              ready_r, load_ready_r, err_range_r, err_align_r;

    logic [IW-1:0]     cpu_idx_s, load_idx_s;
    logic              cpu_in_rng_s, load_in_rng_s, cpu_aligned_s, load_aligned_s;
    logic              clr_last_s, range_set_s, align_set_s;

    logic              ram_we_s, ram_rd_en_s, ram_rd_zero_s;
    logic [AW-1:0]     ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s, ram_rdata_s;

    assign cpu_idx_s      = addr[ADDR_W-1:2];
    assign load_idx_s     = load_addr[ADDR_W-1:2];
    assign cpu_in_rng_s   = in_range(32'(cpu_idx_s), 32'(DEPTH));
    assign load_in_rng_s  = in_range(32'(load_idx_s), 32'(DEPTH));
    assign cpu_aligned_s  = (addr[1:0] == 2'b00);
    assign load_aligned_s = (load_addr[1:0] == 2'b00);
    assign clr_last_s     = (clr_cnt_r == AW'(DEPTH - 1));

    // RAM port mux: clear sweep, host preload or CPU, selected by state
    always_comb begin
        ram_we_s      = 1'b0;
        ram_addr_s    = {AW{1'b0}};
        ram_wdata_s   = {DATA_W{1'b0}};
        ram_rd_en_s   = 1'b0;
        ram_rd_zero_s = 1'b0;
        case (state_r)
            S_CLEAR: begin
                ram_we_s   = 1'b1;
                ram_addr_s = clr_cnt_r;
            end
            S_LOAD: begin
                ram_we_s    = load_valid & load_in_rng_s & load_aligned_s;
                ram_addr_s  = load_idx_s[AW-1:0];
                ram_wdata_s = load_data;
            end
            S_RUN: begin
                ram_we_s      = memWrite & cpu_in_rng_s & cpu_aligned_s;
                ram_addr_s    = cpu_idx_s[AW-1:0];
                ram_wdata_s   = dataWrite;
                ram_rd_en_s   = 1'b1;
                ram_rd_zero_s = ~cpu_in_rng_s;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_CLEAR: begin
                if (clr_last_s) begin
                    next_state_s = load_en ? S_LOAD : S_RUN;
                end else begin
                    next_state_s = S_CLEAR;
                end
            end
            S_LOAD: begin
                if (!load_en) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_LOAD;
                end
            end
            S_RUN: begin
                if (load_en) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            default: begin
                next_state_s = S_CLEAR;
            end
        endcase
    end

    // Every RUN cycle is a CPU read, so an out-of-range address flags even without a store
    assign range_set_s = ((state_r == S_RUN) & ~cpu_in_rng_s)
                       | ((state_r == S_LOAD) & load_valid & ~load_in_rng_s);
    assign align_set_s = ((state_r == S_RUN) & memWrite & ~cpu_aligned_s)
                       | ((state_r == S_LOAD) & load_valid & ~load_aligned_s);

    // FSM, clear counter, handshake outputs and sticky errors (set wins over clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_CLEAR;
            clr_cnt_r    <= {AW{1'b0}};
            ready_r      <= 1'b0;
            load_ready_r <= 1'b0;
            err_range_r  <= 1'b0;
            err_align_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            if (state_r == S_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + AW'(1);
            end
            ready_r      <= (next_state_s == S_RUN);
            load_ready_r <= (next_state_s == S_LOAD);
            err_range_r  <= range_set_s | (err_range_r & ~err_clr);
            err_align_r  <= align_set_s | (err_align_r & ~err_clr);
        end
    end

    sp_word_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we_s),
        .addr    (ram_addr_s),
        .wdata   (ram_wdata_s),
        .rd_en   (ram_rd_en_s),
        .rd_zero (ram_rd_zero_s),
        .rdata   (ram_rdata_s)
    );

    assign dataRead   = ram_rdata_s;
    assign ready      = ready_r;
    assign load_ready = load_ready_r;
    assign err_range  = err_range_r;
    assign err_align  = err_align_r;

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Directed bench for cpu_data_mem_responder; expected load data goes through a scoreboard queue.
module tb_cpu_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [20:0] addr = 21'h0;
    logic [31:0] dataWrite = 32'h0;
    logic        memWrite = 1'b0;
    logic [31:0] dataRead;
    logic        ready;
    logic        load_en = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [20:0] load_addr = 21'h0;
    logic [31:0] load_data = 32'h0;
    logic        err_range;
    logic        err_align;
    logic        err_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    cpu_data_mem_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .dataWrite(dataWrite), .memWrite(memWrite),
        .dataRead(dataRead), .ready(ready), .load_en(load_en), .load_valid(load_valid),
        .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
        .err_range(err_range), .err_align(err_align), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one CPU cycle; the expected load result is queued and checked after the edge
    task automatic cpu_access(input string tag, input logic [20:0] a, input logic we,
                              input logic [31:0] d, input logic [31:0] exp);
        addr = a;
        memWrite = we;
        dataWrite = d;
        exp_q.push_back(exp);
        tick();
        memWrite = 1'b0;
        addr = 21'h0;
        check(tag, dataRead, exp_q.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_lrdy"}, 32'(load_ready), 32'd0);
        check({tag, "_data"}, dataRead, 32'd0);
        check({tag, "_errs"}, {30'd0, err_range, err_align}, 32'd0);
    endtask

    // Count edges until ready (or load_ready) rises, bounded
    task automatic wait_up(input string tag, input logic want_load);
        int n;
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            n++;
            if ((want_load ? load_ready : ready) === 1'b1) break;
        end
        check(tag, 32'(n), 32'd4096);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #20;
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Plain reset, idle, first read of cleared memory
        do_reset("rst1");
        wait_up("clear_len", 1'b0);
        cpu_access("rd_cleared", 21'h00010, 1'b0, 32'h0, 32'h00000000);

        // Preload requested during CLEAR; last beat coincides with dropping load_en
        load_en = 1'b1;
        do_reset("rst2");
        wait_up("clear_to_load", 1'b1);
        check("load_ready_hold", 32'(ready), 32'd0);
        load_valid = 1'b1;
        load_addr = 21'h0; load_data = 32'h11111111; tick();
        load_addr = 21'h4; load_data = 32'h22222222; tick();
        load_addr = 21'h8; load_data = 32'h33333333; load_en = 1'b0; tick();
        load_valid = 1'b0;
        check("load_exit_ready", {30'd0, ready, load_ready}, 32'd2);
        cpu_access("rd_load4", 21'h00004, 1'b0, 32'h0, 32'h22222222);
        cpu_access("rd_load8", 21'h00008, 1'b0, 32'h0, 32'h33333333);

        // Write-first then read back
        cpu_access("wr_first", 21'h00100, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        cpu_access("rd_back", 21'h00100, 1'b0, 32'h0, 32'hDEADBEEF);

        // Out-of-range write
        cpu_access("wr_oor", 21'h1FFFFC, 1'b1, 32'hAAAA5555, 32'h00000000);
        check("err_range_set", 32'(err_range), 32'd1);
        cpu_access("rd_zero_word", 21'h00000, 1'b0, 32'h0, 32'h11111111);
        check("err_range_sticky", 32'(err_range), 32'd1);
        err_clr = 1'b1;
        cpu_access("rd_clr_range", 21'h00000, 1'b0, 32'h0, 32'h11111111);
        err_clr = 1'b0;
        check("err_range_clr", 32'(err_range), 32'd0);

        // Misaligned write, clear-vs-set priority
        cpu_access("wr_misal", 21'h00102, 1'b1, 32'h12345678, 32'hDEADBEEF);
        check("err_align_set", {30'd0, err_range, err_align}, 32'd1);
        cpu_access("rd_word40", 21'h00100, 1'b0, 32'h0, 32'hDEADBEEF);
        err_clr = 1'b1;
        cpu_access("wr_misal_clr", 21'h00101, 1'b1, 32'h0BADF00D, 32'hDEADBEEF);
        check("err_align_set_wins", 32'(err_align), 32'd1);
        cpu_access("rd_clr_align", 21'h00100, 1'b0, 32'h0, 32'hDEADBEEF);
        err_clr = 1'b0;
        check("err_align_clr", 32'(err_align), 32'd0);

        // RUN->LOAD with a store in the transition cycle; dataRead holds in LOAD
        load_en = 1'b1;
        cpu_access("wr_into_load", 21'h00200, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);
        check("load_entry", {30'd0, ready, load_ready}, 32'd1);
        addr = 21'h00100;
        tick();
        tick();
        check("load_hold_data", dataRead, 32'hCAFEF00D);
        load_en = 1'b0;
        addr = 21'h0;
        tick();
        check("run_again", 32'(ready), 32'd1);
        cpu_access("rd_0x200", 21'h00200, 1'b0, 32'h0, 32'hCAFEF00D);

        // Short async reset pulse between edges
        cpu_access("rd_oor", 21'h1FFFFC, 1'b0, 32'h0, 32'h00000000);
        check("err_range_rd", 32'(err_range), 32'd1);
        cpu_access("rd_pre_pulse", 21'h00200, 1'b0, 32'h0, 32'hCAFEF00D);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("pulse");
        wait_up("clear_after_pulse", 1'b0);

        // Reset mid-CLEAR restarts the sweep
        do_reset("rst3");
        for (int i = 0; i < 2000; i++) tick();
        check("mid_clear_ready", 32'(ready), 32'd0);
        do_reset("rst4");
        wait_up("clear_restart", 1'b0);
        cpu_access("rd_after_restart", 21'h00200, 1'b0, 32'h0, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_data_mem_responder.md
Name: cpu_data_mem_responder

Overview:
- Memory-side responder for the vector CPU's scalar data port (addr[20:0], dataWrite, memWrite, dataRead).
- Holds the on-chip word-addressed data RAM and returns load data in time for the M/W pipe register.
- Zero-clears the RAM after reset, then accepts a host preload stream before releasing the CPU to run.
- Flags out-of-range and misaligned accesses with sticky error bits.

Parameters:
ADDR_W, 21, CPU byte-address width
DATA_W, 32, word width
DEPTH, 4096, RAM depth in words; power of two, at most 2^(ADDR_W-2)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
addr  in  ADDR_W  CPU byte address, memory stage
dataWrite  in  DATA_W  CPU store data
memWrite  in  1  CPU store strobe
dataRead  out  DATA_W  registered load data
ready  out  1  1 = RUN state, CPU may execute; CPU is held while 0
load_en  in  1  host requests preload mode
load_valid  in  1  host preload word valid
load_ready  out  1  responder accepts a preload word
load_addr  in  ADDR_W  preload byte address
load_data  in  DATA_W  preload word
err_range  out  1  sticky: word index >= DEPTH
err_align  out  1  sticky: addr[1:0] != 0 on a write
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (rst=0, async): state=CLEAR, clear counter=0, dataRead=0, ready=0, load_ready=0, err_range=0, err_align=0.
- Word index = addr[ADDR_W-1:2]. In range iff index < DEPTH.
- CLEAR state:
  - Writes 0 to word[counter] each cycle; counter increments.
  - After the write of DEPTH-1 (exactly DEPTH cycles), the next state is LOAD if load_en=1, else RUN.
  - CPU and host inputs are ignored; ready=0, load_ready=0.
  - Reset asserted mid-CLEAR restarts the sweep at 0.
- LOAD state:
  - load_ready=1, ready=0.
  - A transfer occurs when load_valid=1 on a rising edge; there is no backpressure.
  - When load_en=0, next state is RUN. A valid beat sampled in that same cycle is still written.
  - CPU inputs are ignored and dataRead holds its last value.
- RUN state:
  - ready=1, load_ready=0.
  - load_en=1 moves to LOAD on the next edge; the CPU access in that cycle is still serviced.
- Read: word[index] sampled at edge N is on dataRead after edge N, for every RUN cycle. Latency is one cycle.
- Write: memWrite=1, in range and aligned -> word[index]=dataWrite at the edge.
  - Write-first: dataRead after that edge equals dataWrite.
- Out of range (CPU or load beat):
  - Write dropped.
  - dataRead=0 for a CPU read.
  - err_range set at the edge, for a CPU access or a load beat.
- Misaligned write (addr[1:0]!=0, CPU or load):
  - Write dropped; err_align set.
  - Misaligned reads are allowed, ignore addr[1:0] and do not flag.
- err_clr=1 clears both errors at the edge. A set in the same cycle wins (flag stays 1).
- No X propagation: dataRead must never take uninitialized RAM contents, which is guaranteed by CLEAR.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} mem_state_t
  - ADDR_W and DATA_W localparams
  - function in_range(index, depth)
- One sub-module, sp_word_ram:
  - single-port, DEPTH x DATA_W, write-first, registered read, one write port.
  - Driven by a mux that selects the clear counter, the load port or the CPU port according to state.
- The FSM, counter, error logic and muxing live in the top.

Test Plan:
- Reset then idle with load_en=0 -> ready=0 for exactly 4096 cycles, then ready=1; read addr 0x00010 -> dataRead=0x00000000.
- load_en=1 during CLEAR; stream load_addr 0x0,0x4,0x8 with data 0x11111111/0x22222222/0x33333333; drop load_en -> in RUN, read 0x4 returns 0x22222222 one cycle later.
- RUN: memWrite=1 addr=0x00100 data=0xDEADBEEF -> dataRead=0xDEADBEEF the next cycle (write-first); next cycle read 0x00100 -> 0xDEADBEEF.
- RUN: write addr=0x1FFFFC (index >= 4096) data=0xAAAA5555 -> err_range=1, dataRead=0; a read at 0x0 is unchanged.
- RUN: write addr=0x00102 -> err_align=1 and word 0x40 unchanged; assert err_clr together with a new misaligned write -> err_align stays 1; err_clr alone -> 0.
- Assert rst=0 mid-CLEAR at cycle 2000, release -> ready rises 4096 cycles after release; an async reset pulse shorter than one clock period still resets all outputs.
